// File: rtl/frame_update_scheduler_if.sv
// Scheduler bus: raster position, per-client update handshake and status.
// The master side is the raster/client fabric, the slave side is the scheduler.
interface frame_update_scheduler_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [9:0]             i_hcount;
  logic [9:0]             i_vcount;
  logic                   i_enable;
  logic [NUM_CLIENTS-1:0] i_client_en;
  logic [NUM_CLIENTS-1:0] i_upd_ack;
  logic                   i_clear_err;
  logic [NUM_CLIENTS-1:0] o_upd_req;
  logic                   o_frame_tick;
  logic                   o_commit;
  logic                   o_busy;
  logic                   o_overrun;
  logic                   o_timeout_err;
  logic [15:0]            o_frame_count;

  modport master (
    output i_hcount, i_vcount, i_enable, i_client_en, i_upd_ack, i_clear_err,
    input  o_upd_req, o_frame_tick, o_commit, o_busy, o_overrun, o_timeout_err,
           o_frame_count
  );

  modport slave (
    input  i_hcount, i_vcount, i_enable, i_client_en, i_upd_ack, i_clear_err,
    output o_upd_req, o_frame_tick, o_commit, o_busy, o_overrun, o_timeout_err,
           o_frame_count
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: during vertical blanking it hands an update
// slot to each enabled client in ascending index order, then pulses commit
// so object registers swap before the next visible frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for the first blanking line (hcount 0)
// ST_GRANT  | one client holds upd_req; waiting for its ack or timeout
// ST_COMMIT | commit pulse cycle; back to idle on the next edge
module frame_update_scheduler #(
  parameter int NUM_CLIENTS    = 4,
  parameter int V_ACTIVE_START = 35,
  parameter int V_ACTIVE_END   = 514,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                     i_clk,
  input logic                     i_reset,
  frame_update_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  // Loaded when a grant is issued; reaching zero on an edge without an ack
  // means the grant has been held for TIMEOUT_CYCLES cycles.
  localparam logic [TMR_W-1:0] TMR_LOAD      = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]       START_LINE    = 10'(V_ACTIVE_END + 1);
  localparam logic [9:0]       DEADLINE_LINE = 10'(V_ACTIVE_START);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]             r_state;
  logic [NUM_CLIENTS-1:0] r_mask;
  logic [IDX_W-1:0]       r_idx;
  logic [TMR_W-1:0]       r_timer;
  logic [NUM_CLIENTS-1:0] r_req;
  logic                   r_frame_tick;
  logic                   r_commit;
  logic                   r_busy;
  logic                   r_overrun;
  logic                   r_timeout_err;
  logic [15:0]            r_frame_count;

  logic                   w_start;
  logic                   w_deadline;
  logic                   w_ack_hit;
  logic                   w_tmr_expired;
  logic                   w_advance;
  logic                   w_timeout;
  logic                   w_commit_set;
  logic [IDX_W-1:0]       w_first_idx;
  logic                   w_first_vld;
  logic [IDX_W-1:0]       w_next_idx;
  logic                   w_next_vld;

  assign w_start = (r_state == ST_IDLE) && bus.i_enable &&
                   (bus.i_hcount == 10'd0) && (bus.i_vcount == START_LINE);

  // Deadline beats everything else in the same cycle, including an ack.
  assign w_deadline = (r_state != ST_IDLE) &&
                      (bus.i_hcount == 10'd0) && (bus.i_vcount == DEADLINE_LINE);

  // Acks only count on the bit that is currently granted.
  assign w_ack_hit     = |(bus.i_upd_ack & r_req);
  assign w_tmr_expired = (r_timer == '0);
  assign w_advance     = (r_state == ST_GRANT) && !w_deadline &&
                         (w_ack_hit || w_tmr_expired);
  assign w_timeout     = (r_state == ST_GRANT) && !w_deadline &&
                         !w_ack_hit && w_tmr_expired;
  assign w_commit_set  = !w_deadline &&
                         ((w_start && !w_first_vld) || (w_advance && !w_next_vld));

  // Lowest enabled client at frame start (taken straight from client_en).
  always_comb begin
    w_first_idx = '0;
    w_first_vld = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (bus.i_client_en[i]) begin
        w_first_idx = IDX_W'(i);
        w_first_vld = 1'b1;
      end
    end
  end

  // Next higher client in the latched mask after the one currently granted.
  always_comb begin
    w_next_idx = '0;
    w_next_vld = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (r_mask[i] && (IDX_W'(i) > r_idx)) begin
        w_next_idx = IDX_W'(i);
        w_next_vld = 1'b1;
      end
    end
  end

  // Frame sequencing: start, back-to-back grants, commit, deadline abort.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_req        <= '0;
      r_frame_tick <= 1'b0;
      r_commit     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      r_commit     <= 1'b0;
      if (w_deadline) begin
        r_state <= ST_IDLE;
        r_req   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_frame_tick <= 1'b1;
              r_busy       <= 1'b1;
              r_mask       <= bus.i_client_en;
              if (w_first_vld) begin
                r_state <= ST_GRANT;
                r_idx   <= w_first_idx;
                r_req   <= NUM_CLIENTS'(1) << w_first_idx;
                r_timer <= TMR_LOAD;
              end else begin
                r_state  <= ST_COMMIT;
                r_commit <= 1'b1;
              end
            end
          end
          ST_GRANT: begin
            if (w_advance) begin
              if (w_next_vld) begin
                r_idx   <= w_next_idx;
                r_req   <= NUM_CLIENTS'(1) << w_next_idx;
                r_timer <= TMR_LOAD;
              end else begin
                r_req    <= '0;
                r_state  <= ST_COMMIT;
                r_commit <= 1'b1;
              end
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          ST_COMMIT: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky error flags; a set in the same cycle as clear_err wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_deadline) begin
        r_overrun <= 1'b1;
      end else if (bus.i_clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.i_clear_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  // Committed-frame counter, updated together with the commit pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_count <= '0;
    end else if (w_commit_set) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign bus.o_upd_req     = r_req;
  assign bus.o_frame_tick  = r_frame_tick;
  assign bus.o_commit      = r_commit;
  assign bus.o_busy        = r_busy;
  assign bus.o_overrun     = r_overrun;
  assign bus.o_timeout_err = r_timeout_err;
  assign bus.o_frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: directed scenarios plus random frames,
// all checked against a frame-level schedule model.
module tb_frame_update_scheduler;
  localparam int NC   = 4;
  localparam int TC   = 16;
  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic reset;

  frame_update_scheduler_if #(.NUM_CLIENTS(NC)) bus ();

  frame_update_scheduler #(
    .NUM_CLIENTS(NC), .V_ACTIVE_START(35), .V_ACTIVE_END(514), .TIMEOUT_CYCLES(TC)
  ) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state carried between frames
  logic [15:0] m_cnt;
  logic        m_ovr, m_tmo;

  // frame plan
  logic       p_enable;
  logic [3:0] p_mask, p_en_mid;
  int         p_hold[NC];
  int         p_dl, p_clear, p_spur;

  // observations of the last frame
  int o_req_cyc[NC];
  int o_commits, o_ticks, o_busy, o_ovr_cyc;
  int o_order[$];

  // schedule and expectation tables
  logic [3:0]  s_req[MAXC];
  logic [3:0]  s_ack[MAXC];
  bit          s_tmo[MAXC];
  logic [3:0]  e_req[MAXC];
  bit          e_tick[MAXC], e_commit[MAXC], e_busy[MAXC];
  bit          e_ovr[MAXC+1], e_tmo[MAXC+1];
  logic [15:0] e_cnt[MAXC];

  task automatic drive_idle();
    bus.i_hcount    = 10'd100;
    bus.i_vcount    = 10'd200;
    bus.i_enable    = 1'b0;
    bus.i_client_en = '0;
    bus.i_upd_ack   = '0;
    bus.i_clear_err = 1'b0;
  endtask

  function automatic int frame_last();
    int t = 1;
    for (int c = 0; c < NC; c++) if (p_mask[c]) t += p_hold[c];
    return (p_enable && p_dl >= 1 && p_dl < t) ? p_dl : t;
  endfunction

  task automatic plan(input bit en, input logic [3:0] mask, input int h0, input int h1,
                      input int h2, input int h3);
    p_enable = en; p_mask = mask; p_en_mid = ~mask;
    p_hold[0] = h0; p_hold[1] = h1; p_hold[2] = h2; p_hold[3] = h3;
    p_dl = 0; p_clear = -1; p_spur = 0;
  endtask

  // Builds the expected per-cycle picture of one frame from the grant
  // schedule, then drives it cycle by cycle and compares every output.
  // Cycle 0 carries the start condition; outputs of cycle k come from edge k-1.
  task automatic run_frame();
    int t, last, len, commit_cyc, prev_idx;
    bit dl_eff, committed, act, tset, oset;
    logic [3:0] ack_v, prev_req;
    for (int k = 0; k < MAXC; k++) begin
      s_req[k] = '0; s_ack[k] = '0; s_tmo[k] = 1'b0;
    end
    t = 1;
    for (int c = 0; c < NC; c++) begin
      if (p_mask[c]) begin
        for (int k = t; k < t + p_hold[c]; k++) s_req[k][c] = 1'b1;
        if (p_hold[c] < TC) s_ack[t + p_hold[c] - 1][c] = 1'b1;
        else s_tmo[t + p_hold[c] - 1] = 1'b1;
        t += p_hold[c];
      end
    end
    commit_cyc = t;
    dl_eff     = p_enable && p_dl >= 1 && p_dl < commit_cyc;
    committed  = p_enable && !dl_eff;
    last       = dl_eff ? p_dl : commit_cyc;
    len        = last + 3;
    e_ovr[0] = m_ovr;
    e_tmo[0] = m_tmo;
    for (int k = 0; k < len; k++) begin
      act         = p_enable && k >= 1 && k <= last;
      e_req[k]    = act ? s_req[k] : 4'b0000;
      e_busy[k]   = act;
      e_tick[k]   = p_enable && k == 1;
      e_commit[k] = committed && k == commit_cyc;
      e_cnt[k]    = (committed && k >= commit_cyc) ? m_cnt + 16'd1 : m_cnt;
      tset = p_enable && s_tmo[k] && (!dl_eff || k < p_dl);
      oset = dl_eff && k == p_dl;
      e_ovr[k+1] = oset ? 1'b1 : (k == p_clear) ? 1'b0 : e_ovr[k];
      e_tmo[k+1] = tset ? 1'b1 : (k == p_clear) ? 1'b0 : e_tmo[k];
    end

    for (int c = 0; c < NC; c++) o_req_cyc[c] = 0;
    o_commits = 0; o_ticks = 0; o_busy = 0; o_ovr_cyc = 0;
    o_order.delete();
    prev_req = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_upd_req !== e_req[k]) begin
        n_fail++; $display("FAIL upd_req cyc=%0d got=%b exp=%b", k, bus.o_upd_req, e_req[k]);
      end
      n_checks++;
      if (bus.o_frame_tick !== e_tick[k]) begin
        n_fail++; $display("FAIL frame_tick cyc=%0d got=%b exp=%b", k, bus.o_frame_tick, e_tick[k]);
      end
      n_checks++;
      if (bus.o_commit !== e_commit[k]) begin
        n_fail++; $display("FAIL commit cyc=%0d got=%b exp=%b", k, bus.o_commit, e_commit[k]);
      end
      n_checks++;
      if (bus.o_busy !== e_busy[k]) begin
        n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, bus.o_busy, e_busy[k]);
      end
      n_checks++;
      if (bus.o_overrun !== e_ovr[k]) begin
        n_fail++; $display("FAIL overrun cyc=%0d got=%b exp=%b", k, bus.o_overrun, e_ovr[k]);
      end
      n_checks++;
      if (bus.o_timeout_err !== e_tmo[k]) begin
        n_fail++; $display("FAIL timeout_err cyc=%0d got=%b exp=%b", k, bus.o_timeout_err, e_tmo[k]);
      end
      n_checks++;
      if (bus.o_frame_count !== e_cnt[k]) begin
        n_fail++; $display("FAIL frame_count cyc=%0d got=%0d exp=%0d", k, bus.o_frame_count, e_cnt[k]);
      end

      for (int c = 0; c < NC; c++) o_req_cyc[c] += int'(bus.o_upd_req[c]);
      o_commits += int'(bus.o_commit);
      o_ticks   += int'(bus.o_frame_tick);
      o_busy    += int'(bus.o_busy);
      o_ovr_cyc += int'(bus.o_overrun);
      if (bus.o_upd_req != prev_req && bus.o_upd_req != 4'b0000) begin
        prev_idx = -1;
        for (int c = 0; c < NC; c++) if (bus.o_upd_req[c]) prev_idx = c;
        o_order.push_back(prev_idx);
      end
      prev_req = bus.o_upd_req;

      bus.i_hcount    = (k == 0 || k == p_dl) ? 10'd0 : 10'(k + 1);
      bus.i_vcount    = (k == 0) ? 10'd515 : (k == p_dl) ? 10'd35 : 10'd516;
      bus.i_enable    = (k == 0) ? p_enable : 1'($urandom);
      bus.i_client_en = (k == 0) ? p_mask : p_en_mid;
      ack_v = p_enable ? s_ack[k] : 4'b0000;
      if (p_spur == 1) ack_v = ack_v | (4'($urandom) & ~s_req[k]);
      else if (p_spur == 2) ack_v = ack_v | (4'b1000 & ~s_req[k]);
      bus.i_upd_ack   = ack_v;
      bus.i_clear_err = (k == p_clear);
    end
    m_cnt = e_cnt[len-1];
    m_ovr = e_ovr[len];
    m_tmo = e_tmo[len];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_upd_req, bus.o_frame_tick, bus.o_commit, bus.o_busy, bus.o_overrun,
         bus.o_timeout_err} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b%b%b%b%b%b exp=0", bus.o_upd_req,
        bus.o_frame_tick, bus.o_commit, bus.o_busy, bus.o_overrun, bus.o_timeout_err);
    end
    n_checks++;
    if (bus.o_frame_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.o_frame_count);
    end
    reset = 1'b0;
    m_cnt = 16'd0; m_ovr = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic test_basic();
    plan(1'b1, 4'b1111, 11, 11, 11, 11);
    run_frame();
    n_checks++;
    if (o_order.size() != 4 || o_order[0] != 0 || o_order[1] != 1 || o_order[2] != 2 ||
        o_order[3] != 3) begin
      n_fail++; $display("FAIL basic_order got_len=%0d exp=0,1,2,3", o_order.size());
    end
    n_checks++;
    if (o_busy != 45 || o_commits != 1) begin
      n_fail++; $display("FAIL basic_busy got busy=%0d commits=%0d exp 45/1", o_busy, o_commits);
    end
    n_checks++;
    if (o_req_cyc[2] != 11 || bus.o_frame_count !== 16'd1) begin
      n_fail++; $display("FAIL basic_hold got req2=%0d cnt=%0d exp 11/1", o_req_cyc[2], bus.o_frame_count);
    end
  endtask

  task automatic test_mask();
    plan(1'b1, 4'b1010, 3, 7, 3, 4);
    p_en_mid = 4'b0101;
    run_frame();
    n_checks++;
    if (o_order.size() != 2 || o_order[0] != 1 || o_order[1] != 3 || o_req_cyc[0] != 0 ||
        o_req_cyc[2] != 0 || o_commits != 1) begin
      n_fail++; $display("FAIL mask_order got_len=%0d r0=%0d r2=%0d commits=%0d exp 2/0/0/1",
        o_order.size(), o_req_cyc[0], o_req_cyc[2], o_commits);
    end
    plan(1'b0, 4'b1111, 2, 2, 2, 2);
    run_frame();
    n_checks++;
    if (o_ticks != 0 || o_commits != 0 || o_busy != 0) begin
      n_fail++; $display("FAIL mask_disabled got ticks=%0d commits=%0d exp 0/0", o_ticks, o_commits);
    end
  endtask

  task automatic test_timeout();
    plan(1'b1, 4'b1111, 5, 5, TC, 5);
    run_frame();
    n_checks++;
    if (o_req_cyc[2] != 16 || o_req_cyc[3] != 5 || o_commits != 1 || bus.o_timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hold got req2=%0d req3=%0d commits=%0d tmo=%b exp 16/5/1/1",
        o_req_cyc[2], o_req_cyc[3], o_commits, bus.o_timeout_err);
    end
  endtask

  task automatic test_overrun();
    plan(1'b1, 4'b0001, TC, 1, 1, 1);
    p_dl = 8;
    p_clear = 9;
    run_frame();
    n_checks++;
    if (o_commits != 0 || o_req_cyc[0] != 8 || o_ovr_cyc != 1 || bus.o_overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_abort got commits=%0d req0=%0d ovr_cyc=%0d exp 0/8/1",
        o_commits, o_req_cyc[0], o_ovr_cyc);
    end
  endtask

  task automatic test_spurious();
    plan(1'b1, 4'b1001, 6, 1, 1, 5);
    p_spur = 2;
    run_frame();
    n_checks++;
    if (o_req_cyc[0] != 6 || o_order.size() != 2 || o_commits != 1) begin
      n_fail++; $display("FAIL spurious_ack got req0=%0d grants=%0d exp 6/2", o_req_cyc[0], o_order.size());
    end
    plan(1'b1, 4'b0011, 4, 5, 1, 1);
    p_dl = 4;
    run_frame();
    n_checks++;
    if (o_req_cyc[1] != 0 || o_commits != 0 || bus.o_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ack_on_deadline got req1=%0d commits=%0d ovr=%b exp 0/0/1",
        o_req_cyc[1], o_commits, bus.o_overrun);
    end
    plan(1'b1, 4'b0001, TC, 1, 1, 1);
    p_clear = TC;
    run_frame();
    n_checks++;
    if (bus.o_timeout_err !== 1'b1 || bus.o_overrun !== 1'b0) begin
      n_fail++; $display("FAIL clear_vs_timeout got tmo=%b ovr=%b exp 1/0", bus.o_timeout_err, bus.o_overrun);
    end
  endtask

  task automatic test_random();
    int last;
    for (int f = 0; f < 40; f++) begin
      p_enable = ($urandom_range(0, 7) != 0);
      p_mask   = 4'($urandom);
      p_en_mid = 4'($urandom);
      for (int c = 0; c < NC; c++)
        p_hold[c] = ($urandom_range(0, 4) == 0) ? TC : int'($urandom_range(1, TC - 1));
      p_spur = int'($urandom_range(0, 1));
      p_dl   = 0;
      last   = frame_last();
      if (last > 1 && $urandom_range(0, 3) == 0) p_dl = int'($urandom_range(1, last - 1));
      last    = frame_last();
      p_clear = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, last + 1)) : -1;
      run_frame();
    end
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk);
    bus.i_hcount = 10'd0; bus.i_vcount = 10'd515; bus.i_enable = 1'b1;
    bus.i_client_en = 4'b0010; bus.i_upd_ack = '0; bus.i_clear_err = 1'b0;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (bus.o_upd_req !== 4'b0010) begin
      n_fail++; $display("FAIL mid_grant_req got=%b exp=0010", bus.o_upd_req);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.o_upd_req, bus.o_frame_tick, bus.o_commit, bus.o_busy, bus.o_overrun,
         bus.o_timeout_err, bus.o_frame_count} !== 25'b0) begin
      n_fail++; $display("FAIL mid_grant_reset got req=%b busy=%b cnt=%0d exp all 0",
        bus.o_upd_req, bus.o_busy, bus.o_frame_count);
    end
    reset = 1'b0;
    m_cnt = 16'd0; m_ovr = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_count;
    m_cnt = 16'hFFFF;
    plan(1'b1, 4'b0000, 1, 1, 1, 1);
    run_frame();
    n_checks++;
    if (bus.o_frame_count !== 16'd0 || o_commits != 1 || o_busy != 1) begin
      n_fail++; $display("FAIL wrap_count got cnt=%0d commits=%0d busy=%0d exp 0/1/1",
        bus.o_frame_count, o_commits, o_busy);
    end
    plan(1'b1, 4'b0100, 1, 1, 3, 1);
    run_frame();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_timeout();
    test_overrun();
    test_spurious();
    test_random();
    test_reset_mid_grant();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
